// File: rtl/channel_wait_generator_pkg.sv
// channel_wait_generator_pkg: shared cycle-state encoding and default wait/timeout clock counts
package channel_wait_generator_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
    localparam int DEFAULT_IO_WAIT_CYCLES  = 2;
    localparam int DEFAULT_MEM_WAIT_CYCLES = 0;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 64;
endpackage

// File: rtl/channel_wait_generator_wait_counter.sv
// channel_wait_generator_wait_counter: loadable saturating counter with terminal flag
// Ports: clock, reset_n (async, active-low); load/load_value preset the count;
// enable steps it (down, or up when COUNT_UP); terminal is count<=TERMINAL (down)
// or count>=TERMINAL (up).
module channel_wait_generator_wait_counter #(
    parameter int WIDTH    = 4,
    parameter bit COUNT_UP = 1'b0,
    parameter int TERMINAL = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             terminal
);
    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);
    logic [WIDTH-1:0] count;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (load) count <= load_value;
        else if (enable) count <= COUNT_UP ? (count == MAX ? count : count + 1'b1)
                                           : (count == '0 ? count : count - 1'b1);
    end
    assign terminal = COUNT_UP ? (count >= TERM) : (count <= TERM);
endmodule

// File: rtl/channel_wait_generator.sv
// channel_wait_generator: drives io_channel_ready low to insert wait states for slow devices
// Ports: clock, reset_n (async, active-low); address_enable, io/memory read/write
// strobes (active-low) and selects form the request; device_busy extends the wait;
// clear_timeout clears timeout_error. Outputs are registered: io_channel_ready
// (0 = wait), cycle_active, access_done (1-clock release pulse), timeout_error (sticky).
module channel_wait_generator
    import channel_wait_generator_pkg::*;
#(
    parameter int IO_WAIT_CYCLES  = DEFAULT_IO_WAIT_CYCLES,
    parameter int MEM_WAIT_CYCLES = DEFAULT_MEM_WAIT_CYCLES,
    parameter int COUNT_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH   = 7
) (
    input  logic clock,
    input  logic reset_n,
    input  logic address_enable,
    input  logic io_read_n,
    input  logic io_write_n,
    input  logic memory_read_n,
    input  logic memory_write_n,
    input  logic io_select,
    input  logic memory_select,
    input  logic device_busy,
    input  logic clear_timeout,
    output logic io_channel_ready,
    output logic cycle_active,
    output logic access_done,
    output logic timeout_error
);
    localparam logic [COUNT_WIDTH-1:0] IO_N  = COUNT_WIDTH'(IO_WAIT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] MEM_N = COUNT_WIDTH'(MEM_WAIT_CYCLES);
    state_t state, state_next;
    logic io_req, mem_req, req, prev_req, start, load;
    logic wait_term, timeout_term, release_wait;
    logic ready_next, active_next, done_next, timeout_next;
    logic [COUNT_WIDTH-1:0] wait_n;
    assign io_req       = io_select & ~address_enable & (~io_read_n | ~io_write_n);
    assign mem_req      = memory_select & (~memory_read_n | ~memory_write_n);
    assign req          = io_req | mem_req;
    assign start        = req & ~prev_req;
    assign wait_n       = io_req ? IO_N : MEM_N;
    assign load         = (state == IDLE) & start;
    assign release_wait = wait_term & ~device_busy;
    channel_wait_generator_wait_counter #(
        .WIDTH(COUNT_WIDTH), .COUNT_UP(1'b0), .TERMINAL(1)
    ) u_wait (
        .clock(clock), .reset_n(reset_n), .load(load), .load_value(wait_n),
        .enable(state == WAIT), .terminal(wait_term)
    );
    channel_wait_generator_wait_counter #(
        .WIDTH(TIMEOUT_WIDTH), .COUNT_UP(1'b1), .TERMINAL(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock(clock), .reset_n(reset_n), .load(load), .load_value(TIMEOUT_WIDTH'(1)),
        .enable(state == WAIT), .terminal(timeout_term)
    );
    // prev_req resets high so a strobe still held across reset is not taken as a new start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            prev_req         <= 1'b1;
            io_channel_ready <= 1'b1;
            cycle_active     <= 1'b0;
            access_done      <= 1'b0;
            timeout_error    <= 1'b0;
        end else begin
            state            <= state_next;
            prev_req         <= req;
            io_channel_ready <= ready_next;
            cycle_active     <= active_next;
            access_done      <= done_next;
            timeout_error    <= timeout_next;
        end
    end
    always_comb begin
        state_next = IDLE;
        unique case (state)
            IDLE:    state_next = !start ? IDLE : (wait_n != '0 || device_busy) ? WAIT : DONE;
            WAIT:    state_next = !req ? IDLE : (release_wait || timeout_term) ? DONE : WAIT;
            DONE:    state_next = req ? DONE : IDLE;
            default: state_next = IDLE;
        endcase
    end
    // A normal release on the same clock as the timeout is not a timeout; an abort never is.
    always_comb begin
        ready_next   = state_next != WAIT;
        active_next  = state_next != IDLE;
        done_next    = (state_next == DONE) && (state != DONE);
        timeout_next = ((state == WAIT) && req && !release_wait && timeout_term)
                     | (timeout_error & ~clear_timeout);
    end
endmodule

// File: tb/tb_channel_wait_generator.sv
// tb_channel_wait_generator: directed self-checking bench for channel_wait_generator
module tb_channel_wait_generator;
    logic clock = 1'b0, reset_n = 1'b1;
    logic address_enable = 1'b0, io_read_n = 1'b1, io_write_n = 1'b1;
    logic memory_read_n = 1'b1, memory_write_n = 1'b1;
    logic io_select = 1'b0, memory_select = 1'b0, device_busy = 1'b0, clear_timeout = 1'b0;
    logic io_channel_ready, cycle_active, access_done, timeout_error;
    int tests = 0, fails = 0;

    channel_wait_generator #(
        .IO_WAIT_CYCLES(2), .MEM_WAIT_CYCLES(0), .COUNT_WIDTH(4),
        .TIMEOUT_CYCLES(64), .TIMEOUT_WIDTH(7)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address_enable(address_enable),
        .io_read_n(io_read_n), .io_write_n(io_write_n),
        .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
        .io_select(io_select), .memory_select(memory_select),
        .device_busy(device_busy), .clear_timeout(clear_timeout),
        .io_channel_ready(io_channel_ready), .cycle_active(cycle_active),
        .access_done(access_done), .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        #2 reset_n = 1'b0;
        #10;
        obs = {io_channel_ready, cycle_active, access_done, timeout_error};
        tests++;
        if (obs !== 4'b1000) begin fails++; $display("FAIL reset_outputs: got %b expected 1000", obs); end
        @(negedge clock) reset_n = 1'b1;
        tick(); tick();
        obs = {io_channel_ready, cycle_active, access_done, timeout_error};
        tests++;
        if (obs !== 4'b1000) begin fails++; $display("FAIL idle_after_reset: got %b expected 1000", obs); end
    endtask

    task automatic test_io_read();
        int lows = 0, dones = 0, done_at = -1;
        logic first;
        io_select = 1'b1; io_read_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) first = io_channel_ready;
            if (io_channel_ready === 1'b0) lows++;
            if (access_done === 1'b1) begin dones++; done_at = i; end
        end
        tests++;
        if (first !== 1'b0) begin fails++; $display("FAIL io_read_latency: got ready %b expected 0", first); end
        tests++;
        if (lows != 2) begin fails++; $display("FAIL io_read_low: got %0d expected 2", lows); end
        tests++;
        if (dones != 1 || done_at != 2) begin fails++; $display("FAIL io_read_done: got %0d pulses at %0d expected 1 at 2", dones, done_at); end
        tests++;
        if (cycle_active !== 1'b1) begin fails++; $display("FAIL io_read_hold_active: got %b expected 1", cycle_active); end
        io_read_n = 1'b1;
        tick();
        tests++;
        if (cycle_active !== 1'b0) begin fails++; $display("FAIL io_read_idle: got %b expected 0", cycle_active); end
        io_select = 1'b0;
    endtask

    task automatic test_mem_read();
        int lows = 0, dones = 0;
        memory_select = 1'b1; memory_read_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (io_channel_ready === 1'b0) lows++;
            if (access_done === 1'b1) dones++;
        end
        tests++;
        if (lows != 0) begin fails++; $display("FAIL mem_read_low: got %0d expected 0", lows); end
        tests++;
        if (dones != 1) begin fails++; $display("FAIL mem_read_done: got %0d expected 1", dones); end
        tests++;
        if (cycle_active !== 1'b1) begin fails++; $display("FAIL mem_read_done_state: got %b expected 1", cycle_active); end
        memory_read_n = 1'b1;
        tick();
        tests++;
        if (cycle_active !== 1'b0) begin fails++; $display("FAIL mem_read_idle: got %b expected 0", cycle_active); end
        memory_select = 1'b0;
    endtask

    task automatic test_busy_write();
        int lows = 0, dones = 0;
        io_select = 1'b1; io_write_n = 1'b0; device_busy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (io_channel_ready === 1'b0) lows++;
            if (access_done === 1'b1) dones++;
            if (i == 3) begin io_read_n = 1'b0; io_write_n = 1'b1; end
        end
        tests++;
        if (lows != 7 || dones != 0) begin fails++; $display("FAIL busy_low: got %0d low %0d done expected 7 low 0 done", lows, dones); end
        device_busy = 1'b0;
        tick();
        tests++;
        if ({io_channel_ready, access_done} !== 2'b11) begin fails++; $display("FAIL busy_release: got %b expected 11", {io_channel_ready, access_done}); end
        io_read_n = 1'b1;
        tick();
        io_select = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        io_select = 1'b1; io_read_n = 1'b0; device_busy = 1'b1;
        tick();
        while (io_channel_ready === 1'b0 && n < 100) begin n++; tick(); end
        tests++;
        if (n != 64) begin fails++; $display("FAIL timeout_low: got %0d expected 64", n); end
        tests++;
        if ({access_done, timeout_error} !== 2'b11) begin fails++; $display("FAIL timeout_flag: got %b expected 11", {access_done, timeout_error}); end
        io_read_n = 1'b1; device_busy = 1'b0;
        tick(); tick();
        tests++;
        if (timeout_error !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b expected 1", timeout_error); end
        clear_timeout = 1'b1;
        tick();
        clear_timeout = 1'b0;
        tests++;
        if (timeout_error !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b expected 0", timeout_error); end
        io_read_n = 1'b0; device_busy = 1'b1; n = 0;
        tick();
        while (io_channel_ready === 1'b0 && n < 100) begin
            n++;
            if (n == 64) clear_timeout = 1'b1;
            tick();
        end
        clear_timeout = 1'b0;
        tests++;
        if (n != 64 || timeout_error !== 1'b1) begin fails++; $display("FAIL timeout_set_wins: got %0d low flag %b expected 64 low flag 1", n, timeout_error); end
        io_read_n = 1'b1; device_busy = 1'b0;
        tick();
        clear_timeout = 1'b1;
        tick();
        clear_timeout = 1'b0;
        io_select = 1'b0;
    endtask

    task automatic test_dma();
        int lows = 0, actives = 0;
        address_enable = 1'b1; io_select = 1'b1; io_read_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (io_channel_ready === 1'b0) lows++;
            if (cycle_active === 1'b1) actives++;
        end
        tests++;
        if (lows != 0 || actives != 0) begin fails++; $display("FAIL dma_ignored: got %0d low %0d active expected 0 0", lows, actives); end
        io_read_n = 1'b1; address_enable = 1'b0; io_select = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int dones = 0;
        logic [3:0] obs;
        io_select = 1'b1; io_read_n = 1'b0; device_busy = 1'b1;
        tick(); tick();
        tests++;
        if (io_channel_ready !== 1'b0) begin fails++; $display("FAIL abort_waiting: got %b expected 0", io_channel_ready); end
        io_read_n = 1'b1;
        tick();
        obs = {io_channel_ready, cycle_active, access_done, timeout_error};
        tests++;
        if (obs !== 4'b1000) begin fails++; $display("FAIL abort_release: got %b expected 1000", obs); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (access_done === 1'b1) dones++;
        end
        tests++;
        if (dones != 0) begin fails++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
        device_busy = 1'b0; io_select = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] obs;
        io_select = 1'b1; io_read_n = 1'b0; device_busy = 1'b1;
        tick();
        #2 reset_n = 1'b0;
        #1 obs = {io_channel_ready, cycle_active};
        tests++;
        if (obs !== 2'b10) begin fails++; $display("FAIL reset_async: got %b expected 10", obs); end
        #1 reset_n = 1'b1;
        tick(); tick();
        obs = {io_channel_ready, cycle_active};
        tests++;
        if (obs !== 2'b10) begin fails++; $display("FAIL reset_held_strobe: got %b expected 10", obs); end
        io_read_n = 1'b1;
        tick();
        io_read_n = 1'b0;
        tick();
        obs = {io_channel_ready, cycle_active};
        tests++;
        if (obs !== 2'b01) begin fails++; $display("FAIL reset_fresh_start: got %b expected 01", obs); end
        io_read_n = 1'b1; device_busy = 1'b0;
        tick(); tick();
        io_select = 1'b0;
    endtask

    initial begin
        test_reset();
        test_io_read();
        test_mem_read();
        test_busy_write();
        test_timeout();
        test_dma();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
